edge_detector_bank: RTL and testbench
=====================================

// Module: edge_detector_bank
// PURPOSE
//  Multi-channel input-event front end. Synchronises WIDTH asynchronous inputs, debounces them,
//  detects rising/falling/both edges per MODE, and emits 1-cycle pulses plus sticky pending bits.
//  IRQ is the OR of the pending bits. Feeds the interrupt/status logic for external buttons and pins.
// PARAMETERS
//  WIDTH        8  number of independent channels
//  SYNC_STAGES  2  synchroniser flops per channel (>=2)
//  DEBOUNCE     4  consecutive cycles a new level must persist before acceptance; 0 = bypass
// PORTS
//  C      in   1      clock; all state updates on rising edge
//  RST    in   1      synchronous reset, ACTIVE-LOW (RST==0 at a C edge resets all state)
//  I      in   WIDTH  raw asynchronous inputs
//  MODE   in   2      00 rise, 01 fall, 10 both, 11 disabled (global, all channels)
//  MASK   in   WIDTH  per-channel enable; 0 suppresses O and PEND set for that channel
//  CLR    in   WIDTH  write-1-to-clear for PEND, sampled each edge
//  O      out  WIDTH  1-cycle edge pulse per channel
//  PEND   out  WIDTH  sticky per-channel event flag
//  IRQ    out  1      |PEND
// BEHAVIOUR
//  Reset (RST==0): sync chain, stab, stab_d, cnt, PEND all 0 -> O=0, PEND=0, IRQ=0 next cycle.
//  Sync: s = output of SYNC_STAGES-deep flop chain per channel.
//  Debounce per channel, counter cnt of width max(1,$clog2(DEBOUNCE+1)):
//   - DEBOUNCE==0: stab <= s every edge.
//   - else: s==stab -> cnt<=0; s!=stab && cnt==DEBOUNCE-1 -> stab<=s, cnt<=0; else cnt<=cnt+1.
//   - Any return of s to stab before acceptance restarts the count (glitch rejected).
//  stab_d <= stab every edge.
//  Edge: rise=stab&~stab_d, fall=~stab&stab_d. O = MASK & sel(MODE) (combinational from regs).
//   MODE 11 -> O=0. MODE/MASK changes take effect same cycle; no pipeline flush.
//  Latency: I change captured at edge 1 -> stab updates at edge SYNC_STAGES+max(DEBOUNCE,1);
//   O high for exactly the following cycle.
//  PEND[i] <= (PEND[i] & ~CLR[i]) | O[i]; set wins over simultaneous CLR. IRQ = |PEND (comb).
//  Masked channels still track stab/stab_d; unmasking never creates a spurious pulse.
//  Input already high at reset release is seen as a rising edge after the normal latency.
//  Reset mid-debounce discards the partial count; no pulse results from pre-reset activity.
// TESTING  (WIDTH=4, SYNC_STAGES=2, DEBOUNCE=3, MODE=00, MASK=F, CLR=0 unless stated)
//  1 RST=0 3 cycles, I=4'hF -> O=0, PEND=0, IRQ=0; release, hold I=F -> O=4'hF for one cycle
//    after edge 5; PEND=4'hF and IRQ=1 from edge 6.
//  2 I[0] high 2 cycles then low -> O[0] never set; I[0] high 3 cycles -> exactly one O[0] pulse.
//  3 MODE=10, I[1] high 10 cycles then low -> two O[1] pulses 10 cycles apart; MODE=01 -> only fall.
//  4 PEND[2]=1, CLR[2]=1 on the same edge that new O[2] sets -> PEND[2] stays 1;
//    CLR[2]=1 alone -> PEND[2]=0 and IRQ=0 after that edge.
//  5 MASK[3]=0 during I[3] rise -> no O[3], PEND[3]=0; set MASK[3]=1 later -> still no pulse.
//  6 I[0] high, RST=0 one cycle at cnt=2 -> all state 0; I low afterwards -> no O for 6 cycles.

Source files
------------

// File: rtl/edge_detector_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_detector_bank: synchronise, debounce and edge-detect WIDTH inputs   |
// | into 1-cycle pulses, sticky pending flags and an IRQ.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module edge_detector_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic             C,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] MASK,
  input  logic [WIDTH-1:0] CLR,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] PEND,
  output logic             IRQ
);

  localparam logic [1:0] c_MODE_RISE = 2'b00;
  localparam logic [1:0] c_MODE_FALL = 2'b01;
  localparam logic [1:0] c_MODE_BOTH = 2'b10;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] r_stab;
  logic [WIDTH-1:0] r_stab_d;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_sel;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge C) begin
      if (!RST) begin
        r_chain <= '0;
      end else begin
        r_chain <= {r_chain[SYNC_STAGES-2:0], I[gi]};
      end
    end

    assign w_sync[gi] = r_chain[SYNC_STAGES-1];
  end

  if (DEBOUNCE == 0) begin : g_bypass
    always_ff @(posedge C) begin
      if (!RST) begin
        r_stab <= '0;
      end else begin
        r_stab <= w_sync;
      end
    end
  end else begin : g_debounce
    localparam int c_CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);

    logic [c_CNT_W-1:0] r_cnt [WIDTH];

    // The count only advances while the synchronised level disagrees with the
    // accepted one, so any glitch back to the old level restarts it.
    always_ff @(posedge C) begin
      if (!RST) begin
        r_stab <= '0;
        for (int k = 0; k < WIDTH; k++) begin
          r_cnt[k] <= '0;
        end
      end else begin
        for (int k = 0; k < WIDTH; k++) begin
          if (w_sync[k] == r_stab[k]) begin
            r_cnt[k] <= '0;
          end else if (r_cnt[k] == c_CNT_LAST) begin
            r_stab[k] <= w_sync[k];
            r_cnt[k]  <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + c_CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge C) begin
    if (!RST) begin
      r_stab_d <= '0;
      r_pend   <= '0;
    end else begin
      r_stab_d <= r_stab;
      r_pend   <= (r_pend & ~CLR) | O;
    end
  end

  // MODE and MASK gate the registered edges directly, so they act immediately.
  always_comb begin
    w_rise = r_stab & ~r_stab_d;
    w_fall = ~r_stab & r_stab_d;
    case (MODE)
      c_MODE_RISE: w_sel = w_rise;
      c_MODE_FALL: w_sel = w_fall;
      c_MODE_BOTH: w_sel = w_rise | w_fall;
      default:     w_sel = '0;
    endcase
  end

  assign O    = MASK & w_sel;
  assign PEND = r_pend;
  assign IRQ  = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_edge_detector_bank: directed bench with a cycle-level reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_edge_detector_bank;

  localparam int W   = 4;
  localparam int SYN = 2;
  localparam int DEB = 3;

  logic         C = 1'b0;
  logic         RST;
  logic [W-1:0] I;
  logic [1:0]   MODE;
  logic [W-1:0] MASK;
  logic [W-1:0] CLR;
  logic [W-1:0] O;
  logic [W-1:0] PEND;
  logic         IRQ;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  edge_detector_bank #(.WIDTH(W), .SYNC_STAGES(SYN), .DEBOUNCE(DEB)) dut (
    .C(C), .RST(RST), .I(I), .MODE(MODE), .MASK(MASK), .CLR(CLR),
    .O(O), .PEND(PEND), .IRQ(IRQ)
  );

  always #5 C = ~C;

  // Reference: a SYN-deep delay of I, then a level is accepted once the last
  // DEB delayed samples all disagree with the currently accepted level.
  logic [W-1:0] m_pipe [SYN];
  logic [W-1:0] m_hist [$];
  logic [W-1:0] m_stab  = '0;
  logic [W-1:0] m_stabd = '0;
  logic [W-1:0] m_pend  = '0;

  function automatic logic [W-1:0] model_o();
    logic [W-1:0] r;
    logic [W-1:0] f;
    r = m_stab & ~m_stabd;
    f = ~m_stab & m_stabd;
    case (MODE)
      2'b00:   return MASK & r;
      2'b01:   return MASK & f;
      2'b10:   return MASK & (r | f);
      default: return '0;
    endcase
  endfunction

  always @(posedge C) begin
    logic [W-1:0] o_now;
    logic [W-1:0] s;
    logic [W-1:0] nstab;
    bit           all_diff;
    if (!RST) begin
      for (int k = 0; k < SYN; k++) m_pipe[k] = '0;
      m_hist.delete();
      m_stab  = '0;
      m_stabd = '0;
      m_pend  = '0;
    end else begin
      o_now = model_o();
      s = m_pipe[SYN-1];
      for (int k = SYN-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = I;
      m_hist.push_back(s);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      nstab = m_stab;
      for (int ch = 0; ch < W; ch++) begin
        all_diff = (m_hist.size() == DEB);
        foreach (m_hist[j]) if (m_hist[j][ch] == m_stab[ch]) all_diff = 1'b0;
        if (all_diff) nstab[ch] = ~m_stab[ch];
      end
      m_stabd = m_stab;
      m_stab  = nstab;
      m_pend  = (m_pend & ~CLR) | o_now;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge C) begin
    if (chk_en) begin
      check("cyc O",    32'(O),    32'(model_o()));
      check("cyc PEND", 32'(PEND), 32'(m_pend));
      check("cyc IRQ",  32'(IRQ),  32'(|m_pend));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge C);
      #2;
    end
  endtask

  initial begin
    RST = 1'b0; I = 4'hF; MODE = 2'b00; MASK = 4'hF; CLR = 4'h0;

    // 1: reset with inputs high, then release
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst O", 32'(O), 32'h0);
    check("rst PEND", 32'(PEND), 32'h0);
    check("rst IRQ", 32'(IRQ), 32'h0);
    RST = 1'b1;
    tick(4);
    check("t1 O before", 32'(O), 32'h0);
    tick(1);
    check("t1 O pulse", 32'(O), 32'hF);
    check("t1 PEND early", 32'(PEND), 32'h0);
    tick(1);
    check("t1 O end", 32'(O), 32'h0);
    check("t1 PEND", 32'(PEND), 32'hF);
    check("t1 IRQ", 32'(IRQ), 32'h1);
    CLR = 4'hF; tick(1); CLR = 4'h0;
    check("t1 PEND clr", 32'(PEND), 32'h0);

    // 2: glitch rejection and minimum accepted width
    I = 4'hE; tick(8);
    check("t2 PEND idle", 32'(PEND), 32'h0);
    I = 4'hF; tick(2); I = 4'hE; tick(8);
    check("t2 PEND glitch", 32'(PEND), 32'h0);
    I = 4'hF; tick(3); I = 4'hE; tick(2);
    check("t2 O pulse", 32'(O), 32'h1);
    tick(1);
    check("t2 O end", 32'(O), 32'h0);
    check("t2 PEND", 32'(PEND), 32'h1);
    tick(6);
    CLR = 4'hF; tick(1); CLR = 4'h0;

    // 3: both-edge then fall-only
    I = 4'h0; tick(8);
    MODE = 2'b10; I = 4'h2; tick(5);
    check("t3 both rise", 32'(O), 32'h2);
    tick(5); I = 4'h0; tick(5);
    check("t3 both fall", 32'(O), 32'h2);
    tick(1);
    check("t3 PEND", 32'(PEND), 32'h2);
    CLR = 4'h2; tick(1); CLR = 4'h0;
    MODE = 2'b01; I = 4'h2; tick(5);
    check("t3 fall no rise", 32'(O), 32'h0);
    tick(5); I = 4'h0; tick(5);
    check("t3 fall pulse", 32'(O), 32'h2);
    tick(1);
    check("t3 PEND fall", 32'(PEND), 32'h2);
    CLR = 4'hF; tick(1); CLR = 4'h0;

    // 4: set wins over simultaneous clear
    MODE = 2'b00; I = 4'h4; tick(5);
    check("t4 O rise", 32'(O), 32'h4);
    tick(1);
    check("t4 PEND set", 32'(PEND), 32'h4);
    tick(2);
    MODE = 2'b10; I = 4'h0; tick(5);
    check("t4 O fall", 32'(O), 32'h4);
    CLR = 4'h4; tick(1);
    check("t4 PEND set wins", 32'(PEND), 32'h4);
    tick(1); CLR = 4'h0;
    check("t4 PEND cleared", 32'(PEND), 32'h0);
    check("t4 IRQ low", 32'(IRQ), 32'h0);

    // 5: masked channel, late unmask, disabled mode
    MODE = 2'b00; MASK = 4'h7; I = 4'h8; tick(5);
    check("t5 masked O", 32'(O), 32'h0);
    tick(3);
    check("t5 masked PEND", 32'(PEND), 32'h0);
    MASK = 4'hF; tick(1);
    check("t5 unmask O", 32'(O), 32'h0);
    tick(5);
    check("t5 unmask PEND", 32'(PEND), 32'h0);
    MODE = 2'b11; I = 4'h9; tick(8);
    check("t5 disabled PEND", 32'(PEND), 32'h0);
    MODE = 2'b00;

    // 6: reset in the middle of a debounce count
    I = 4'h0; tick(8);
    I = 4'h1; tick(4);
    RST = 1'b0; I = 4'h0; tick(1);
    check("t6 rst O", 32'(O), 32'h0);
    check("t6 rst PEND", 32'(PEND), 32'h0);
    RST = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick(1);
      check("t6 no pulse", 32'(O), 32'h0);
    end
    check("t6 PEND", 32'(PEND), 32'h0);

    tick(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
